// File: rtl/regfile_arbiter_pkg.sv
// Shared constants and encodings for the two-port register-file arbiter.
package regfile_arbiter_pkg;

  // Default widths, matching the register-file header.
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // Logic levels and active-low enable levels.
  localparam logic HIGH     = 1'b1;
  localparam logic LOW      = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Port indices.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Transaction FSM: one access every three clocks.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-request round-robin grant picker; purely combinational.
module rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    gnt_valid = |req;
    gnt_sel   = PORT0;
    if (req == 2'b11) gnt_sel = ~last_grant;
    else if (req[1])  gnt_sel = PORT1;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates a single-port register file between the core (port 0) and the
// debug/DMA side (port 1) with a req/ack handshake and round-robin priority.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                we_q, we_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]   rf_d_in_q, rf_d_in_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                gnt_valid;
  logic                gnt_sel;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_sel    (gnt_sel)
  );

  // Next-state, latched transaction fields and handshake/regfile outputs.
  // The regfile address/data registers double as the latched request fields,
  // so they naturally hold their value outside ACCESS.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    rf_addr_d    = rf_addr_q;
    rf_d_in_d    = rf_d_in_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0         = LOW;
    ack1         = LOW;
    rf_we_       = DISABLE_;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          sel_d     = gnt_sel;
          we_d      = (gnt_sel == PORT1) ? we1    : we0;
          rf_addr_d = (gnt_sel == PORT1) ? addr1  : addr0;
          rf_d_in_d = (gnt_sel == PORT1) ? wdata1 : wdata0;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Reset gates the strobe directly so an aborted write never lands.
        if (we_q && !reset) rf_we_ = ENABLE_;
        if (!we_q) begin
          if (sel_q == PORT1) rdata1_d = rf_d_out;
          else                rdata0_d = rf_d_out;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!reset) begin
          ack0 = (sel_q == PORT0);
          ack1 = (sel_q == PORT1);
        end
        last_grant_d = sel_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= PORT0;
      we_q         <= LOW;
      last_grant_q <= PORT1;
      rf_addr_q    <= '0;
      rf_d_in_q    <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      rf_addr_q    <= rf_addr_d;
      rf_d_in_q    <= rf_d_in_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign rf_addr = rf_addr_q;
  assign rf_d_in = rf_d_in_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: behavioural regfile plus a transaction-level
// reference (memory image, per-port read data, round-robin pointer).
module tb_regfile_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in;
  logic          rf_we_;
  logic [DW-1:0] rf_d_out;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .rf_addr(rf_addr), .rf_d_in(rf_d_in), .rf_we_(rf_we_), .rf_d_out(rf_d_out)
  );

  // Behavioural single-port regfile: combinational read, clocked write.
  logic [DW-1:0] rf_mem [32] = '{default: '0};
  assign rf_d_out = rf_mem[rf_addr];
  always @(posedge clk) if (rf_we_ === 1'b0) rf_mem[rf_addr] <= rf_d_in;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_ref [32];
  logic [DW-1:0] rdata_ref [2];
  bit            lg_ref;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit p, input bit r);
    if (p) req1 = r; else req0 = r;
  endtask

  task automatic chk_rdata();
    chk("rdata0", rdata0, rdata_ref[0]);
    chk("rdata1", rdata1, rdata_ref[1]);
  endtask

  // Transaction-level completion per the spec rules.
  task automatic complete(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (w) mem_ref[a] = d;
    else   rdata_ref[p] = mem_ref[a];
    lg_ref = p;
  endtask

  // Issue one request on one port, or one on each port in the same cycle.
  // Must be called at a falling edge while the arbiter is idle.
  task automatic txn(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit            w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    bit            first, p;
    int            n, kmax;
    w[0] = w0; w[1] = w1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    req0 = v0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = v1; we1 = w1; addr1 = a1; wdata1 = d1;
    n     = int'(v0) + int'(v1);
    first = (v0 && v1) ? !lg_ref : v1;
    kmax  = (n == 2) ? 6 : 3;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 1 || (k == 4 && n == 2)) begin
        p = (k == 1) ? first : !first;
        chk("rf_addr_access", rf_addr, a[p]);
        chk("rf_we_access", rf_we_, !w[p]);
        if (w[p]) chk("rf_d_in_access", rf_d_in, d[p]);
        chk("ack_in_access", {ack1, ack0}, 2'b00);
      end else if (k == 2 || (k == 5 && n == 2)) begin
        p = (k == 2) ? first : !first;
        chk("ack_port", {ack1, ack0}, p ? 2'b10 : 2'b01);
        chk("rf_we_in_ack", rf_we_, 1'b1);
        complete(p, w[p], a[p], d[p]);
        chk_rdata();
        drive_req(p, 1'b0);
      end else begin
        chk("ack_idle", {ack1, ack0}, 2'b00);
        chk("rf_we_idle", rf_we_, 1'b1);
      end
    end
  endtask

  initial begin
    bit            exp_p;
    bit            rv0, rv1, rw0, rw1;
    logic [AW-1:0] ra0, ra1;
    for (int i = 0; i < 32; i++) mem_ref[i] = '0;
    rdata_ref[0] = '0; rdata_ref[1] = '0;
    lg_ref = 1'b1;

    // Reset held with a pending request.
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'h1234_5678;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_ack", {ack1, ack0}, 2'b00);
      chk("reset_rf_we", rf_we_, 1'b1);
      chk("reset_rf_addr", rf_addr, '0);
      chk_rdata();
    end
    reset = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("post_reset_ack", {ack1, ack0}, 2'b00);

    // Port 0 write, then port 1 reads it back.
    txn(1'b1, 1'b1, 5'd3, 32'h0000_00A5, 1'b0, 1'b0, '0, '0);
    txn(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd3, '0);
    chk("rdata1_a5", rdata1, 32'h0000_00A5);

    // Simultaneous reads of addr 0.
    txn(1'b1, 1'b0, 5'd0, '0, 1'b1, 1'b0, 5'd0, '0);

    // Port 1 writes i to addr i, port 0 reads it back.
    for (int i = 0; i < 32; i++) begin
      txn(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AW'(i), DW'(i));
      txn(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
      chk("loop_rdata0", rdata0, DW'(i));
    end

    // Reset during the ACCESS cycle of a port 0 write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("abort_rf_addr", rf_addr, 5'd7);
    reset = 1'b1;
    #1;
    chk("abort_rf_we_gated", rf_we_, 1'b1);
    req0 = 1'b0;
    @(negedge clk);
    chk("abort_no_ack", {ack1, ack0}, 2'b00);
    reset = 1'b0;
    rdata_ref[0] = '0; rdata_ref[1] = '0; lg_ref = 1'b1;
    chk_rdata();
    @(negedge clk);
    chk("abort_idle_ack", {ack1, ack0}, 2'b00);

    // Both requests held for six transactions: grants alternate.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd0;
    exp_p = !lg_ref;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k % 3 == 2) begin
        chk("fair_ack", {ack1, ack0}, exp_p ? 2'b10 : 2'b01);
        complete(exp_p, 1'b0, 5'd0, '0);
        exp_p = !exp_p;
        if (k == 17) begin req0 = 1'b0; req1 = 1'b0; end
      end else begin
        chk("fair_no_ack", {ack1, ack0}, 2'b00);
      end
    end
    chk_rdata();

    // The aborted write must not have landed.
    txn(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd7, '0);
    chk("addr7_prior", rdata1, 32'd7);

    // Port 0 keeps req0 high through ack0 with a new address.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
    @(negedge clk);
    chk("hold_rf_addr1", rf_addr, 5'd5);
    @(negedge clk);
    chk("hold_ack1", {ack1, ack0}, 2'b01);
    complete(1'b0, 1'b0, 5'd5, '0);
    addr0 = 5'd9;
    @(negedge clk);
    chk("hold_idle_no_ack", {ack1, ack0}, 2'b00);
    @(negedge clk);
    chk("hold_rf_addr2", rf_addr, 5'd9);
    chk("hold_access_no_ack", {ack1, ack0}, 2'b00);
    @(negedge clk);
    chk("hold_ack2", {ack1, ack0}, 2'b01);
    complete(1'b0, 1'b0, 5'd9, '0);
    chk_rdata();
    req0 = 1'b0;
    @(negedge clk);
    chk("hold_no_dup_ack", {ack1, ack0}, 2'b00);

    // Randomized single and simultaneous transactions.
    for (int t = 0; t < 40; t++) begin
      rv0 = 1'($urandom_range(0, 1));
      rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      rw0 = 1'($urandom_range(0, 1));
      rw1 = 1'($urandom_range(0, 1));
      ra0 = AW'($urandom_range(0, 31));
      ra1 = (t % 4 == 0) ? ra0 : AW'($urandom_range(0, 31));
      txn(rv0, rw0, ra0, $urandom, rv1, rw1, ra1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
